mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 32, request address width.
REQ-002 SHALL have parameter DATA_W, 128, memory block width.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports p0_req_addr/p1_req_addr  input  ADDR_W  requester block address (p0 = I-side cache controller, p1 = D-side cache controller).
REQ-006 SHALL have ports p0_req_datain/p1_req_datain  input  DATA_W  write-back data from requester.
REQ-007 SHALL have ports p0_req_rw/p1_req_rw  input  1  0 = read (fill), 1 = write (write-back).
REQ-008 SHALL have ports p0_req_valid/p1_req_valid  input  1  request pending; held high until matching ready pulse.
REQ-009 SHALL have ports p0_req_dataout/p1_req_dataout  output  DATA_W  fill data returned to requester.
REQ-010 SHALL have ports p0_req_ready/p1_req_ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have ports mem_req_addr  output  ADDR_W, mem_req_dataout  output  DATA_W, mem_req_rw  output  1, mem_req_valid  output  1: memory request bus.
REQ-012 SHALL have ports mem_req_datain  input  DATA_W, mem_req_ready  input  1: memory response bus.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 In IDLE, if any px_req_valid is high, SHALL select one requester, register its addr/datain/rw and the grant index, and go to BUSY next cycle.
REQ-015 Selection SHALL be round-robin: single requester wins alone; if both are valid, the requester not granted last wins.
REQ-016 In BUSY, mem_req_valid SHALL be 1 and mem_req_addr/dataout/rw SHALL be the registered values, stable for the whole BUSY period.
REQ-017 A memory transaction SHALL complete on the first rising edge in BUSY where mem_req_ready is 1; for reads, mem_req_datain is captured at that edge.
REQ-018 On completion the FSM SHALL go to DONE; in DONE, granted px_req_ready = 1 for exactly one cycle, px_req_dataout = captured data (reads) or unchanged (writes); next state IDLE.
REQ-019 The non-granted requester's ready SHALL stay 0; its dataout SHALL hold its last value.
REQ-020 The last-grant register SHALL update at the IDLE->BUSY transition.
REQ-021 Requests SHALL NOT be sampled in BUSY or DONE; a new grant happens no earlier than the cycle after DONE.
REQ-022 Minimum latency: valid high in IDLE cycle N, mem_req_valid in N+1, ready pulse in N+2 if mem_req_ready is already high.
REQ-023 If the granted requester drops valid during BUSY, the transaction SHALL still complete and pulse ready.
REQ-024 mem_req_valid SHALL be 0 in IDLE and DONE; mem_req_addr/dataout/rw SHALL be 0 in IDLE.

Reset
REQ-025 While reset is high at a rising edge: state = IDLE, all outputs = 0, captured data = 0, last-grant = p1 (so p0 wins the first tie).
REQ-026 Reset asserted in BUSY or DONE SHALL abort the transaction with no ready pulse issued.

Structure
REQ-027 Package mem_arb_pkg SHALL hold the state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and default ADDR_W/DATA_W constants.
REQ-028 Round-robin selection SHALL live in sub-module rr_arbiter2 (inputs: two valids, last-grant; outputs: grant index, any-valid), purely combinational.
REQ-029 All other logic SHALL be in mem_port_arbiter: FSM, request registers, data capture, last-grant register.

Verification
REQ-030 p0 read addr 32'hAB00 alone, mem_req_ready = 1 -> mem_req_addr = 32'hAB00 and rw = 0 one cycle later; p0_req_ready pulse the next cycle with p0_req_dataout = 128'h3344.
REQ-031 p0 and p1 valid on the same cycle after reset -> p0 granted first; p1 (write 128'h1122 to 32'hBB00) granted in the IDLE after p0's DONE; mem_req_dataout = 128'h1122, mem_req_rw = 1.
REQ-032 Both valid continuously for 4 transactions -> grant order p0, p1, p0, p1.
REQ-033 mem_req_ready low for 3 cycles in BUSY, then high with datain 128'h5566 -> mem_req_valid and address stable throughout; single ready pulse with data 128'h5566.
REQ-034 Reset pulsed during BUSY -> next cycle mem_req_valid = 0, no px_req_ready pulse; the next tie goes to p0.
REQ-035 p1 drops valid mid-BUSY -> transaction completes, p1_req_ready pulses once, p0 unaffected.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding
// and default bus widths.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester and memory-side signals of the arbiter. The arbiter
// itself keeps flat ports; the testbench and surrounding logic use this
// bundle to wire requesters and the memory model to it.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
);
  logic [ADDR_W-1:0] p0_req_addr;
  logic [DATA_W-1:0] p0_req_datain;
  logic              p0_req_rw;
  logic              p0_req_valid;
  logic [DATA_W-1:0] p0_req_dataout;
  logic              p0_req_ready;

  logic [ADDR_W-1:0] p1_req_addr;
  logic [DATA_W-1:0] p1_req_datain;
  logic              p1_req_rw;
  logic              p1_req_valid;
  logic [DATA_W-1:0] p1_req_dataout;
  logic              p1_req_ready;

  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_dataout;
  logic              mem_req_rw;
  logic              mem_req_valid;
  logic [DATA_W-1:0] mem_req_datain;
  logic              mem_req_ready;

  // Requesters and memory model side.
  modport master (
    output p0_req_addr, p0_req_datain, p0_req_rw, p0_req_valid,
    input  p0_req_dataout, p0_req_ready,
    output p1_req_addr, p1_req_datain, p1_req_rw, p1_req_valid,
    input  p1_req_dataout, p1_req_ready,
    input  mem_req_addr, mem_req_dataout, mem_req_rw, mem_req_valid,
    output mem_req_datain, mem_req_ready
  );

  // Arbiter side.
  modport slave (
    input  p0_req_addr, p0_req_datain, p0_req_rw, p0_req_valid,
    output p0_req_dataout, p0_req_ready,
    input  p1_req_addr, p1_req_datain, p1_req_rw, p1_req_valid,
    output p1_req_dataout, p1_req_ready,
    output mem_req_addr, mem_req_dataout, mem_req_rw, mem_req_valid,
    input  mem_req_datain, mem_req_ready
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin selector. A lone requester always wins; on a tie the
// requester that was not granted last time wins. grant: 0 = p0, 1 = p1.
module rr_arbiter2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant,
  output logic any_valid
);

  assign any_valid = valid0 | valid1;
  assign grant     = (valid0 && valid1) ? ~last_grant : valid1;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the I-side (p0) and D-side (p1) cache
// controllers. One transaction at a time: IDLE picks a requester and latches
// its request, BUSY presents it to memory until mem_req_ready, DONE pulses
// the winner's ready with the fill data.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [DATA_W-1:0] p0_req_datain,
  input  logic              p0_req_rw,
  input  logic              p0_req_valid,
  output logic [DATA_W-1:0] p0_req_dataout,
  output logic              p0_req_ready,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [DATA_W-1:0] p1_req_datain,
  input  logic              p1_req_rw,
  input  logic              p1_req_valid,
  output logic [DATA_W-1:0] p1_req_dataout,
  output logic              p1_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_dataout,
  output logic              mem_req_rw,
  output logic              mem_req_valid,
  input  logic [DATA_W-1:0] mem_req_datain,
  input  logic              mem_req_ready
);

  state_t            state, next_state;
  logic              grant, any_valid;
  logic              grant_q;       // requester owning the current transaction
  logic              last_grant_q;  // round-robin history
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              rw_q;
  logic [DATA_W-1:0] p0_data_q, p1_data_q;

  rr_arbiter2 u_rr (
    .valid0     (p0_req_valid),
    .valid1     (p1_req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .any_valid  (any_valid)
  );

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decode and bus outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    next_state      = state;
    mem_req_valid   = 1'b0;
    mem_req_addr    = '0;
    mem_req_dataout = '0;
    mem_req_rw      = 1'b0;
    p0_req_ready    = 1'b0;
    p1_req_ready    = 1'b0;
    case (state)
      IDLE: if (any_valid) next_state = BUSY;
      BUSY: begin
        mem_req_valid   = 1'b1;
        mem_req_addr    = addr_q;
        mem_req_dataout = data_q;
        mem_req_rw      = rw_q;
        if (mem_req_ready) next_state = DONE;
      end
      DONE: begin
        p0_req_ready = ~grant_q;
        p1_req_ready = grant_q;
        next_state   = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request latch at grant time and fill-data capture at memory completion.
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;  // p0 wins the first tie out of reset
      addr_q       <= '0;
      data_q       <= '0;
      rw_q         <= 1'b0;
      p0_data_q    <= '0;
      p1_data_q    <= '0;
    end else begin
      if (state == IDLE && any_valid) begin
        grant_q      <= grant;
        last_grant_q <= grant;
        addr_q       <= grant ? p1_req_addr   : p0_req_addr;
        data_q       <= grant ? p1_req_datain : p0_req_datain;
        rw_q         <= grant ? p1_req_rw     : p0_req_rw;
      end
      if (state == BUSY && mem_req_ready && !rw_q) begin
        if (grant_q) p1_data_q <= mem_req_datain;
        else         p0_data_q <= mem_req_datain;
      end
    end
  end

  assign p0_req_dataout = p0_data_q;
  assign p1_req_dataout = p1_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Stimulus pushes expected memory
// transactions and requester responses into queues; a monitor pops and
// compares them whenever the DUT presents a memory completion or a ready.
module tb_mem_port_arbiter;

  typedef struct {
    logic [31:0]  addr;
    logic         rw;
    logic [127:0] data;
  } mem_txn_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(128)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(128)) dut (
    .clock           (clock),
    .reset           (reset),
    .p0_req_addr     (bus.p0_req_addr),
    .p0_req_datain   (bus.p0_req_datain),
    .p0_req_rw       (bus.p0_req_rw),
    .p0_req_valid    (bus.p0_req_valid),
    .p0_req_dataout  (bus.p0_req_dataout),
    .p0_req_ready    (bus.p0_req_ready),
    .p1_req_addr     (bus.p1_req_addr),
    .p1_req_datain   (bus.p1_req_datain),
    .p1_req_rw       (bus.p1_req_rw),
    .p1_req_valid    (bus.p1_req_valid),
    .p1_req_dataout  (bus.p1_req_dataout),
    .p1_req_ready    (bus.p1_req_ready),
    .mem_req_addr    (bus.mem_req_addr),
    .mem_req_dataout (bus.mem_req_dataout),
    .mem_req_rw      (bus.mem_req_rw),
    .mem_req_valid   (bus.mem_req_valid),
    .mem_req_datain  (bus.mem_req_datain),
    .mem_req_ready   (bus.mem_req_ready)
  );

  int total = 0;
  int bad   = 0;

  mem_txn_t     exp_mem[$];
  logic [127:0] exp_rsp0[$];
  logic [127:0] exp_rsp1[$];
  logic [127:0] exp_last0 = '0;  // expected held dataout of each requester
  logic [127:0] exp_last1 = '0;
  logic [127:0] mem_rd [logic [31:0]];
  int           wait_cfg = 0;    // BUSY cycles with mem_req_ready low
  int           busy_len = 0;    // length of the last completed BUSY period

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model: drives ready/datain shortly after each rising edge.
  initial begin
    int cnt = 0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_req_datain = 128'hDEAD;
    forever begin
      @(posedge clock);
      #1;
      if (bus.mem_req_valid) begin
        if (cnt >= wait_cfg) begin
          bus.mem_req_ready  = 1'b1;
          bus.mem_req_datain = mem_rd.exists(bus.mem_req_addr) ? mem_rd[bus.mem_req_addr] : 128'hBAD;
        end else begin
          bus.mem_req_ready  = 1'b0;
          bus.mem_req_datain = 128'hDEAD;
        end
        cnt++;
      end else begin
        bus.mem_req_ready  = 1'b0;
        bus.mem_req_datain = 128'hDEAD;
        cnt = 0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic         prev_valid = 1'b0;
    logic [31:0]  prev_addr  = '0;
    logic         prev_rw    = 1'b0;
    logic [127:0] prev_data  = '0;
    int           run_len    = 0;
    mem_txn_t     t;
    logic [127:0] r;
    forever begin
      @(negedge clock);
      if (bus.mem_req_valid) begin
        run_len++;
        if (prev_valid) begin
          check("mem_addr_stable", 256'(bus.mem_req_addr), 256'(prev_addr));
          check("mem_rw_stable", 256'(bus.mem_req_rw), 256'(prev_rw));
          check("mem_data_stable", 256'(bus.mem_req_dataout), 256'(prev_data));
        end
        if (bus.mem_req_ready) begin
          busy_len = run_len;
          if (exp_mem.size() == 0) begin
            check("unexpected_mem_txn", 256'(1), 256'(0));
          end else begin
            t = exp_mem.pop_front();
            check("mem_addr", 256'(bus.mem_req_addr), 256'(t.addr));
            check("mem_rw", 256'(bus.mem_req_rw), 256'(t.rw));
            check("mem_dataout", 256'(bus.mem_req_dataout), 256'(t.data));
          end
        end
      end else begin
        run_len = 0;
      end
      prev_valid = bus.mem_req_valid;
      prev_addr  = bus.mem_req_addr;
      prev_rw    = bus.mem_req_rw;
      prev_data  = bus.mem_req_dataout;

      if (bus.p0_req_ready && bus.p1_req_ready)
        check("both_ready", 256'(1), 256'(0));
      if (bus.p0_req_ready) begin
        if (exp_rsp0.size() == 0) begin
          check("unexpected_p0_ready", 256'(1), 256'(0));
        end else begin
          r = exp_rsp0.pop_front();
          exp_last0 = r;
          check("p0_dataout", 256'(bus.p0_req_dataout), 256'(r));
          check("p1_hold_on_p0", 256'(bus.p1_req_dataout), 256'(exp_last1));
        end
      end
      if (bus.p1_req_ready) begin
        if (exp_rsp1.size() == 0) begin
          check("unexpected_p1_ready", 256'(1), 256'(0));
        end else begin
          r = exp_rsp1.pop_front();
          exp_last1 = r;
          check("p1_dataout", 256'(bus.p1_req_dataout), 256'(r));
          check("p0_hold_on_p1", 256'(bus.p0_req_dataout), 256'(exp_last0));
        end
      end
    end
  end

  // Bounded wait for a requester's ready pulse, sampled on the falling edge.
  task automatic wait_ready(input bit port);
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if ((port ? bus.p1_req_ready : bus.p0_req_ready) === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check(port ? "p1_ready_timeout" : "p0_ready_timeout", 256'(0), 256'(1));
  endtask

  // Raise a request now (caller is at a falling edge), hold it until ready.
  task automatic do_req(input bit port, input logic [31:0] addr,
                        input logic [127:0] din, input logic rw);
    if (port) begin
      bus.p1_req_addr = addr; bus.p1_req_datain = din; bus.p1_req_rw = rw; bus.p1_req_valid = 1'b1;
    end else begin
      bus.p0_req_addr = addr; bus.p0_req_datain = din; bus.p0_req_rw = rw; bus.p0_req_valid = 1'b1;
    end
    wait_ready(port);
    if (port) bus.p1_req_valid = 1'b0;
    else      bus.p0_req_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    bus.p0_req_valid = 1'b0;
    bus.p1_req_valid = 1'b0;
    exp_last0 = '0;
    exp_last1 = '0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.p0_req_addr = '0; bus.p0_req_datain = '0; bus.p0_req_rw = 1'b0; bus.p0_req_valid = 1'b0;
    bus.p1_req_addr = '0; bus.p1_req_datain = '0; bus.p1_req_rw = 1'b0; bus.p1_req_valid = 1'b0;
    mem_rd[32'hAB00] = 128'h3344;
    mem_rd[32'hAB10] = 128'h7788;
    mem_rd[32'hC000] = 128'hC0C0;
    mem_rd[32'hC100] = 128'hC1C1;
    mem_rd[32'hE000] = 128'h5566;
    mem_rd[32'hF000] = 128'hF0F0;
    mem_rd[32'hF100] = 128'hF1F1;

    // Reset state.
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("rst_mem_valid", 256'(bus.mem_req_valid), 256'(0));
    check("rst_mem_addr", 256'(bus.mem_req_addr), 256'(0));
    check("rst_mem_dataout", 256'(bus.mem_req_dataout), 256'(0));
    check("rst_mem_rw", 256'(bus.mem_req_rw), 256'(0));
    check("rst_p0_ready", 256'(bus.p0_req_ready), 256'(0));
    check("rst_p1_ready", 256'(bus.p1_req_ready), 256'(0));
    check("rst_p0_dataout", 256'(bus.p0_req_dataout), 256'(0));
    check("rst_p1_dataout", 256'(bus.p1_req_dataout), 256'(0));

    // Single p0 read with memory ready at once: minimum latency.
    wait_cfg = 0;
    exp_mem.push_back('{addr: 32'hAB00, rw: 1'b0, data: 128'h0});
    exp_rsp0.push_back(128'h3344);
    @(negedge clock);
    bus.p0_req_addr = 32'hAB00; bus.p0_req_datain = '0; bus.p0_req_rw = 1'b0; bus.p0_req_valid = 1'b1;
    @(negedge clock);
    check("lat_mem_valid", 256'(bus.mem_req_valid), 256'(1));
    check("lat_mem_addr", 256'(bus.mem_req_addr), 256'(32'hAB00));
    check("lat_mem_rw", 256'(bus.mem_req_rw), 256'(0));
    @(negedge clock);
    check("lat_p0_ready", 256'(bus.p0_req_ready), 256'(1));
    bus.p0_req_valid = 1'b0;

    // Tie right after reset: p0 first, then the p1 write-back.
    do_reset();
    exp_mem.push_back('{addr: 32'hAB10, rw: 1'b0, data: 128'h0});
    exp_mem.push_back('{addr: 32'hBB00, rw: 1'b1, data: 128'h1122});
    exp_rsp0.push_back(128'h7788);
    exp_rsp1.push_back(128'h0);
    fork
      do_req(1'b0, 32'hAB10, 128'h0, 1'b0);
      do_req(1'b1, 32'hBB00, 128'h1122, 1'b1);
    join

    // Both requesters busy for four transactions: p0, p1, p0, p1.
    exp_mem.push_back('{addr: 32'hC000, rw: 1'b0, data: 128'h0});
    exp_mem.push_back('{addr: 32'hD000, rw: 1'b1, data: 128'hD0D0});
    exp_mem.push_back('{addr: 32'hC100, rw: 1'b0, data: 128'h0});
    exp_mem.push_back('{addr: 32'hD100, rw: 1'b1, data: 128'hD1D1});
    exp_rsp0.push_back(128'hC0C0);
    exp_rsp0.push_back(128'hC1C1);
    exp_rsp1.push_back(128'h0);
    exp_rsp1.push_back(128'h0);
    @(negedge clock);
    fork
      begin do_req(1'b0, 32'hC000, 128'h0, 1'b0); do_req(1'b0, 32'hC100, 128'h0, 1'b0); end
      begin do_req(1'b1, 32'hD000, 128'hD0D0, 1'b1); do_req(1'b1, 32'hD100, 128'hD1D1, 1'b1); end
    join

    // Memory stalls three cycles in BUSY.
    wait_cfg = 3;
    exp_mem.push_back('{addr: 32'hE000, rw: 1'b0, data: 128'h0});
    exp_rsp0.push_back(128'h5566);
    @(negedge clock);
    do_req(1'b0, 32'hE000, 128'h0, 1'b0);
    check("stall_busy_len", 256'(busy_len), 256'(4));

    // Reset mid-BUSY aborts the p0 read; next tie goes to p0 again.
    wait_cfg = 10;
    @(negedge clock);
    bus.p0_req_addr = 32'hF000; bus.p0_req_datain = '0; bus.p0_req_rw = 1'b0; bus.p0_req_valid = 1'b1;
    repeat (3) @(negedge clock);
    check("abort_in_busy", 256'(bus.mem_req_valid), 256'(1));
    reset = 1'b1;
    bus.p0_req_valid = 1'b0;
    exp_last0 = '0;
    exp_last1 = '0;
    @(negedge clock);
    check("abort_mem_valid", 256'(bus.mem_req_valid), 256'(0));
    check("abort_p0_ready", 256'(bus.p0_req_ready), 256'(0));
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("abort_p0_dataout", 256'(bus.p0_req_dataout), 256'(0));
    wait_cfg = 0;
    exp_mem.push_back('{addr: 32'hF100, rw: 1'b0, data: 128'h0});
    exp_mem.push_back('{addr: 32'hF200, rw: 1'b1, data: 128'hF2F2});
    exp_rsp0.push_back(128'hF1F1);
    exp_rsp1.push_back(128'h0);
    fork
      do_req(1'b0, 32'hF100, 128'h0, 1'b0);
      do_req(1'b1, 32'hF200, 128'hF2F2, 1'b1);
    join

    // p1 drops valid while its write-back is in BUSY.
    wait_cfg = 3;
    exp_mem.push_back('{addr: 32'hA000, rw: 1'b1, data: 128'hAAAA});
    exp_rsp1.push_back(128'h0);
    @(negedge clock);
    bus.p1_req_addr = 32'hA000; bus.p1_req_datain = 128'hAAAA; bus.p1_req_rw = 1'b1; bus.p1_req_valid = 1'b1;
    repeat (2) @(negedge clock);
    check("drop_in_busy", 256'(bus.mem_req_valid), 256'(1));
    bus.p1_req_valid = 1'b0;
    wait_ready(1'b1);
    check("drop_p0_dataout", 256'(bus.p0_req_dataout), 256'(128'hF1F1));

    repeat (5) @(negedge clock);
    check("mem_queue_empty", 256'(exp_mem.size()), 256'(0));
    check("p0_queue_empty", 256'(exp_rsp0.size()), 256'(0));
    check("p1_queue_empty", 256'(exp_rsp1.size()), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
